// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle MIPS control unit (state sequencer, datapath selects, ALU decode)
module mc_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCEn,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state,
    output logic       illegal
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXECUTE = 4'd6, S_ALUWB  = 4'd7,
        S_BRANCH  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     cur, nxt, eff;
    logic [1:0] alu_op;
    logic       pc_write, branch, funct_ok, bad_instr;

    always_ff @(posedge clk) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        funct_ok = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
                   (funct == 6'b100101) || (funct == 6'b101010);
        case (alu_op)
            2'b00:   ALUControl = 3'b010;
            2'b01:   ALUControl = 3'b110;
            default: begin
                case (funct)
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default:   ALUControl = 3'b010;
                endcase
            end
        endcase
    end

    // While reset is held, outputs decode as FETCH so the datapath sees a quiet, known setup.
    always_comb begin
        eff       = reset ? S_FETCH : cur;
        nxt       = S_FETCH;
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSrc     = 2'b00;
        alu_op    = 2'b00;
        pc_write  = 1'b0;
        branch    = 1'b0;
        bad_instr = 1'b0;
        case (eff)
            S_FETCH: begin
                IRWrite  = 1'b1;
                ALUSrcB  = 2'b01;
                pc_write = 1'b1;
                nxt      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE: begin
                        nxt       = S_EXECUTE;
                        bad_instr = !funct_ok;
                    end
                    OP_BEQ:  nxt = S_BRANCH;
                    OP_ADDI: nxt = S_ADDIEX;
                    OP_J:    nxt = S_JUMP;
                    default: begin
                        nxt       = S_FETCH;
                        bad_instr = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                nxt  = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b10;
                nxt     = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = S_ADDIWB;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
        PCEn    = pc_write | (branch & zero);
        illegal = bad_instr;
        if (reset) begin
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCEn     = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - randomized check of mc_control_unit against an instruction-level reference model
module tb_mc_control_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA, illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    mc_control_unit dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl), .state(state),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, PCSrc, ALUControl, illegal};
    endfunction

    function automatic bit funct_known(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    // Visit order of one instruction, fetch first.
    function automatic void path_of(input logic [5:0] o, output int p[$]);
        p = {0, 1};
        case (o)
            6'b100011: p = {p, 2, 3, 4};
            6'b101011: p = {p, 2, 5};
            6'b000000: p = {p, 6, 7};
            6'b001000: p = {p, 9, 10};
            6'b000100: p = {p, 8};
            6'b000010: p = {p, 11};
            default: ;
        endcase
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [15:0] expect_vec(input int st, input logic [5:0] o,
                                               input logic [5:0] f, input logic z);
        logic iord = 0, mw = 0, irw = 0, pcen = 0, rd = 0, m2r = 0, rw = 0, sa = 0, ill = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] ac = 3'b010;
        case (st)
            0:  begin irw = 1; pcen = 1; sb = 2'b01; end
            1:  begin
                    sb  = 2'b11;
                    ill = !(o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
                          || (o == 6'b000000 && !funct_known(f));
                end
            2:  begin sa = 1; sb = 2'b10; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin sa = 1; ac = rtype_alu(f); end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pcen = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pcen = 1; end
            default: ;
        endcase
        return {iord, mw, irw, pcen, rd, m2r, rw, sa, sb, ps, ac, ill};
    endfunction

    // Called #1 after a rising edge with the DUT expected in FETCH.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic bz);
        int p[$];
        logic z;
        path_of(o, p);
        op = o;
        funct = f;
        foreach (p[i]) begin
            z = (p[i] == 8) ? bz : 1'($urandom_range(0, 1));
            zero = z;
            #1;
            check($sformatf("state op=%b step%0d", o, i), 32'(state), 32'(p[i]));
            check($sformatf("outs op=%b f=%b st=%0d", o, f, p[i]), 32'(dut_vec()),
                  32'(expect_vec(p[i], o, f, z)));
            @(posedge clk);
            #1;
        end
        check($sformatf("return op=%b", o), 32'(state), 32'd0);
    endtask

    logic [15:0] rst_vec;

    initial begin
        logic [5:0] ops[6];
        logic [5:0] fns[5];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        reset = 1'b1;
        op = 6'b100011;
        funct = 6'b100000;
        zero = 1'b1;
        // FETCH decode with every write enable held off.
        rst_vec = expect_vec(0, op, funct, 1'b0);
        rst_vec[13] = 1'b0;
        rst_vec[12] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset outs", 32'(dut_vec()), 32'(rst_vec));
            check("reset state", 32'(state), 32'd0);
        end
        reset = 1'b0;

        run_instr(6'b100011, 6'b100000, 1'b0);
        run_instr(6'b101011, 6'b100000, 1'b0);
        foreach (fns[i]) run_instr(6'b000000, fns[i], 1'b0);
        run_instr(6'b000000, 6'b111001, 1'b0);
        run_instr(6'b000100, 6'b000000, 1'b1);
        run_instr(6'b000100, 6'b000000, 1'b0);
        run_instr(6'b001000, 6'b010101, 1'b0);
        run_instr(6'b000010, 6'b000000, 1'b1);
        run_instr(6'b111111, 6'b100000, 1'b0);

        // Abort a lw in MEMRD: reset forces FETCH and the writeback never happens.
        op = 6'b100011;
        repeat (3) @(posedge clk);
        #1;
        check("abort in memrd", 32'(state), 32'd3);
        reset = 1'b1;
        #1;
        check("abort reset outs", 32'(dut_vec()), 32'(rst_vec));
        @(posedge clk);
        #1;
        check("abort to fetch", 32'(state), 32'd0);
        check("abort regwrite", 32'(RegWrite), 32'd0);
        reset = 1'b0;
        #1;
        check("abort fetch outs", 32'(dut_vec()), 32'(expect_vec(0, op, funct, zero)));
        @(posedge clk);
        #1;
        check("abort decode", 32'(state), 32'd1);
        check("abort no write", 32'({RegWrite, MemWrite}), 32'd0);
        op = 6'b111111;
        @(posedge clk);
        #1;
        check("abort resync", 32'(state), 32'd0);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] o, f;
            o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            f = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(o, f, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
